// File: rtl/gpio_hs_pkg.sv
// Shared types and constants for the GPIO handshake sequencer.
// Holds the FSM state type, the step count and the fixed drive/expect table.
package gpio_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_e;

    // Steps 0..4 expect a response; step 5 is the terminal pattern.
    localparam int unsigned NUM_STEPS = 6;
    localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

    // Pattern byte driven to the far end for each step.
    function automatic logic [7:0] driveByte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA0;
            3'd1:    b = 8'h0B;
            3'd2:    b = 8'hAB;
            3'd3:    b = 8'h01;
            3'd4:    b = 8'h02;
            default: b = 8'h04;
        endcase
        return b;
    endfunction

    // Response byte expected back for each step. The terminal step has no
    // response, so its entry is never compared.
    function automatic logic [7:0] expectByte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hF0;
            3'd1:    b = 8'h0F;
            3'd2:    b = 8'h00;
            3'd3:    b = 8'h01;
            3'd4:    b = 8'h03;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/gpio_hs_sync.sv
// Two-flop synchronizer for the far-end response byte followed by a
// stability filter. o_match pulses for one cycle once the synchronized byte
// has equalled i_expect for STABLE_CYCLES consecutive armed cycles.
module gpio_hs_sync #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_clock,
    input  logic       i_rstn,
    input  logic [7:0] i_data,
    input  logic [7:0] i_expect,
    input  logic       i_arm,
    output logic       o_match
);

    // The run counter only needs to reach STABLE_CYCLES-1; the final
    // matching cycle is recognised combinationally.
    localparam int unsigned CW          = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

    logic [7:0]    r_meta;
    logic [7:0]    r_sync;
    logic [CW-1:0] r_stable;
    logic          w_equal;

    assign w_equal = (r_sync == i_expect);
    assign o_match = i_arm && w_equal && (r_stable == STABLE_LAST);

    // Bring the asynchronous pad byte into the clock domain.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_meta <= 8'h00;
            r_sync <= 8'h00;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
        end
    end

    // Count consecutive matching cycles; any mismatch or disarm restarts it.
    always_ff @(posedge i_clock or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stable <= '0;
        end else if (!i_arm || !w_equal || o_match) begin
            r_stable <= '0;
        end else begin
            r_stable <= r_stable + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_handshake_seq.sv
// GPIO handshake sequencer: drives a fixed pattern byte per step, waits for
// the far end to echo the matching response, and ends in PASS or FAIL.
module gpio_handshake_seq
    import gpio_hs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 25000,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic [7:0]  chk_lo_in,
    output logic [7:0]  chk_hi_out,
    output logic        chk_hi_oeb,
    output logic [2:0]  step,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic [14:0] timeout_cnt
);

    // The timeout fires on the WAIT cycle that brings the counter to
    // TIMEOUT_CYCLES, i.e. when the old value is TIMEOUT_CYCLES-1.
    localparam logic [14:0] TIMEOUT_LAST = 15'(TIMEOUT_CYCLES - 1);
    localparam logic [14:0] CNT_MAX      = '1;

    logic [1:0]  r_rstSync;
    logic        w_rstn;
    state_e      r_state;
    logic [2:0]  r_step;
    logic [7:0]  r_out;
    logic        r_oeb;
    logic        r_busy;
    logic        r_pass;
    logic        r_fail;
    logic [14:0] r_cnt;
    logic [7:0]  w_expect;
    logic        w_arm;
    logic        w_match;

    // Reset asserts immediately but releases only after two clock edges.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstn   = r_rstSync[1];
    assign w_expect = expectByte(r_step);
    assign w_arm    = (r_state == ST_WAIT);

    gpio_hs_sync #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .i_clock  (clock),
        .i_rstn   (w_rstn),
        .i_data   (chk_lo_in),
        .i_expect (w_expect),
        .i_arm    (w_arm),
        .o_match  (w_match)
    );

    // Sequencer FSM with step register, wait counter and registered outputs.
    always_ff @(posedge clock or negedge w_rstn) begin
        if (!w_rstn) begin
            r_state <= ST_IDLE;
            r_step  <= 3'd0;
            r_out   <= 8'h00;
            r_oeb   <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_cnt   <= 15'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        r_state <= ST_DRIVE;
                        r_step  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    r_out <= driveByte(r_step);
                    r_oeb <= 1'b0;
                    r_cnt <= 15'd0;
                    if (r_step == LAST_STEP) begin
                        r_state <= ST_PASS;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b1;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 15'd1;
                    end
                    // An acceptance wins over a timeout in the same cycle.
                    if (w_match) begin
                        r_step  <= r_step + 3'd1;
                        r_state <= ST_DRIVE;
                    end else if (r_cnt >= TIMEOUT_LAST) begin
                        r_state <= ST_FAIL;
                        r_busy  <= 1'b0;
                        r_fail  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign chk_hi_out  = r_out;
    assign chk_hi_oeb  = r_oeb;
    assign step        = r_step;
    assign busy        = r_busy;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout_cnt = r_cnt;

endmodule

// File: tb/tb_gpio_handshake_seq.sv
// Bench for gpio_handshake_seq: directed scenario sequence with a randomized
// far-end responder and noise, checked every cycle against a rule-level model.
module tb_gpio_handshake_seq;

    localparam int TO = 100;
    localparam int ST = 4;

    localparam int M_IDLE  = 0;
    localparam int M_DRIVE = 1;
    localparam int M_WAIT  = 2;
    localparam int M_PASS  = 3;
    localparam int M_DONE_BAD = 4;

    logic        clock;
    logic        resetb;
    logic        start;
    logic [7:0]  chk_lo_in;
    logic [7:0]  chk_hi_out;
    logic        chk_hi_oeb;
    logic [2:0]  step;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [14:0] timeout_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] drvTbl [6] = '{8'hA0, 8'h0B, 8'hAB, 8'h01, 8'h02, 8'h04};
    logic [7:0] expTbl [6] = '{8'hF0, 8'h0F, 8'h00, 8'h01, 8'h03, 8'h00};

    // Reference model state
    int         mMode, mStep, mCnt, mRun, mHold;
    logic [7:0] mOut, s1, s2, mSeen;
    logic       mOeb, mBusy, mPass, mFail;

    // Responder / noise / walk recording
    logic        respOn, noiseOn;
    logic [7:0]  lastSeen, prevOut;
    int          respWait, respTarget;
    logic [47:0] walk;
    int          walkLen;

    gpio_handshake_seq #(
        .TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES  (ST)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .start       (start),
        .chk_lo_in   (chk_lo_in),
        .chk_hi_out  (chk_hi_out),
        .chk_hi_oeb  (chk_hi_oeb),
        .step        (step),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .timeout_cnt (timeout_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Rule-level model: the response is seen two cycles late, a step is
    // accepted after ST consecutive matching waiting cycles, and the wait
    // times out on its TO-th cycle. Reset release takes two extra edges.
    always @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            mMode = M_IDLE; mStep = 0; mOut = 8'h00; mOeb = 1'b1;
            mBusy = 1'b0; mPass = 1'b0; mFail = 1'b0; mCnt = 0; mRun = 0;
            s1 = 8'h00; s2 = 8'h00; mHold = 2;
        end else if (mHold > 0) begin
            mHold = mHold - 1;
        end else begin
            mSeen = s2;
            s2 = s1;
            s1 = chk_lo_in;
            if (mMode == M_IDLE || mMode == M_PASS || mMode == M_DONE_BAD) begin
                if (start) begin
                    mMode = M_DRIVE; mStep = 0; mBusy = 1'b1;
                    mPass = 1'b0; mFail = 1'b0;
                end
            end else if (mMode == M_DRIVE) begin
                mOut = drvTbl[mStep]; mOeb = 1'b0; mCnt = 0; mRun = 0;
                if (mStep == 5) begin
                    mMode = M_PASS; mPass = 1'b1; mBusy = 1'b0;
                end else begin
                    mMode = M_WAIT;
                end
            end else begin
                if (mCnt < 32767) mCnt = mCnt + 1;
                mRun = (mSeen == expTbl[mStep]) ? mRun + 1 : 0;
                if (mRun == ST) begin
                    mStep = mStep + 1; mMode = M_DRIVE; mRun = 0;
                end else if (mCnt >= TO) begin
                    mMode = M_DONE_BAD; mFail = 1'b1; mBusy = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] expectFor(input logic [7:0] b, input logic [7:0] dflt);
        for (int i = 0; i < 5; i++) begin
            if (drvTbl[i] == b) return expTbl[i];
        end
        return dflt;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, " chk_hi_out"},  32'(chk_hi_out),  32'(mOut));
        checkEq({tag, " chk_hi_oeb"},  32'(chk_hi_oeb),  32'(mOeb));
        checkEq({tag, " step"},        32'(step),        32'(mStep));
        checkEq({tag, " busy"},        32'(busy),        32'(mBusy));
        checkEq({tag, " pass"},        32'(pass),        32'(mPass));
        checkEq({tag, " fail"},        32'(fail),        32'(mFail));
        checkEq({tag, " timeout_cnt"}, 32'(timeout_cnt), 32'(mCnt));
    endtask

    // Advance whole cycles: sample at the falling edge, check against the
    // model, then update the responder / noise for the next rising edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clock);
            if (chk_hi_out != prevOut) begin
                walk    = {walk[39:0], chk_hi_out};
                walkLen = walkLen + 1;
                prevOut = chk_hi_out;
            end
            checkOutput("cycle");
            if (respOn) begin
                if (chk_hi_out != lastSeen) begin
                    lastSeen   = chk_hi_out;
                    respWait   = 0;
                    respTarget = int'($urandom_range(6, 14));
                end else if (respWait < respTarget) begin
                    respWait = respWait + 1;
                    if (respWait == respTarget) chk_lo_in = expectFor(chk_hi_out, chk_lo_in);
                end
            end
            if (noiseOn) chk_lo_in = 8'($urandom_range(1, 255));
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
    endtask

    task automatic enableResponder();
        respOn     = 1'b1;
        lastSeen   = chk_hi_out;
        respWait   = 0;
        respTarget = int'($urandom_range(6, 14));
    endtask

    task automatic checkResetValues(input string tag);
        checkEq({tag, " out"},  32'(chk_hi_out),  32'h00);
        checkEq({tag, " oeb"},  32'(chk_hi_oeb),  32'h1);
        checkEq({tag, " step"}, 32'(step),        32'h0);
        checkEq({tag, " busy"}, 32'(busy),        32'h0);
        checkEq({tag, " pass"}, 32'(pass),        32'h0);
        checkEq({tag, " fail"}, 32'(fail),        32'h0);
        checkEq({tag, " cnt"},  32'(timeout_cnt), 32'h0);
    endtask

    initial begin
        int n;
        resetb = 1'b1; start = 1'b0; chk_lo_in = 8'h00;
        respOn = 1'b0; noiseOn = 1'b0; lastSeen = 8'h00; prevOut = 8'h00;
        respWait = 0; respTarget = 0; walk = '0; walkLen = 0;
        #2 resetb = 1'b0;
        applyStimulus(3);
        checkResetValues("reset");
        resetb = 1'b1;
        applyStimulus(4);

        // Glitch rejection at step 0
        pulseStart();
        applyStimulus(1);
        checkEq("step0 drive", 32'(chk_hi_out), 32'hA0);
        checkEq("step0 busy",  32'(busy),       32'h1);
        chk_lo_in = 8'hF0; applyStimulus(2);
        chk_lo_in = 8'h00; applyStimulus(3);
        checkEq("glitch step held", 32'(step), 32'h0);
        chk_lo_in = 8'hF0;
        n = 0;
        while (step == 3'd0 && n < 20) begin applyStimulus(1); n++; end
        checkEq("glitch accept latency", 32'(n), 32'(2 + ST));

        // Complete the handshake with a randomized responder
        enableResponder();
        n = 0;
        while (!pass && n < 600) begin applyStimulus(1); n++; end
        checkEq("handshake pass", 32'(pass), 32'h1);
        checkEq("walk length", 32'(walkLen), 32'd6);
        checkEq("walk first", 32'(walk[47:24]), 32'h00A00BAB);
        checkEq("walk last",  32'(walk[23:0]),  32'h00010204);
        checkEq("pass hold out", 32'(chk_hi_out), 32'h04);

        // Restart after PASS
        pulseStart();
        checkEq("restart pass clr", 32'(pass), 32'h0);
        checkEq("restart step", 32'(step), 32'h0);
        applyStimulus(1);
        checkEq("restart drive", 32'(chk_hi_out), 32'hA0);

        // Start while busy at step 1
        n = 0;
        while (chk_hi_out != 8'h0B && n < 200) begin applyStimulus(1); n++; end
        checkEq("reach step1", 32'(chk_hi_out), 32'h0B);
        pulseStart();
        applyStimulus(2);
        checkEq("busy start step", 32'(step), 32'h1);
        checkEq("busy start out",  32'(chk_hi_out), 32'h0B);

        // Timeout at step 2
        n = 0;
        while (chk_hi_out != 8'hAB && n < 200) begin applyStimulus(1); n++; end
        checkEq("reach step2", 32'(chk_hi_out), 32'hAB);
        respOn = 1'b0; noiseOn = 1'b1;
        n = 0;
        while (!fail && n < 300) begin applyStimulus(1); n++; end
        noiseOn = 1'b0;
        checkEq("timeout cycle", 32'(n), 32'(TO));
        checkEq("timeout fail", 32'(fail), 32'h1);
        checkEq("timeout cnt",  32'(timeout_cnt), 32'(TO));
        checkEq("timeout out",  32'(chk_hi_out), 32'hAB);
        checkEq("timeout pass", 32'(pass), 32'h0);

        // Restart from the timed-out state, then reset mid-wait at step 3
        enableResponder();
        pulseStart();
        n = 0;
        while (chk_hi_out != 8'h01 && n < 300) begin applyStimulus(1); n++; end
        checkEq("reach step3", 32'(chk_hi_out), 32'h01);
        applyStimulus(3);
        #3 resetb = 1'b0;
        #1 checkResetValues("async reset");
        checkOutput("async reset model");
        respOn = 1'b0; chk_lo_in = 8'h00;
        applyStimulus(2);
        resetb = 1'b1;
        applyStimulus(4);
        checkEq("idle after reset", 32'(busy), 32'h0);
        pulseStart();
        applyStimulus(1);
        checkEq("redrive out",  32'(chk_hi_out), 32'hA0);
        checkEq("redrive oeb",  32'(chk_hi_oeb), 32'h0);
        checkEq("redrive step", 32'(step), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_handshake_seq.md
GPIO_HANDSHAKE_SEQ -- requirements
Module: gpio_handshake_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 25000, is the maximum number of cycles to wait for each expected response.
REQ-002 Parameter STABLE_CYCLES, default 4, is the number of consecutive cycles a response must match before it is accepted.
REQ-003 clock  input  1  single clock for all logic.
REQ-004 resetb  input  1  asynchronous, active-low reset; its release is synchronized internally to clock.
REQ-005 start  input  1  one-cycle pulse that begins the sequence; ignored unless the state is IDLE, PASS or FAIL.
REQ-006 chk_lo_in  input  8  response byte from the far end (pads mprj_io[23:16]), asynchronous to clock.
REQ-007 chk_hi_out  output  8  pattern byte driven to the far end (pads mprj_io[31:24]).
REQ-008 chk_hi_oeb  output  1  active-low output enable for chk_hi_out.
REQ-009 step  output  3  index of the current step, 0..5.
REQ-010 busy  output  1  high in DRIVE and WAIT.
REQ-011 pass  output  1  held high in PASS.
REQ-012 fail  output  1  held high in FAIL.
REQ-013 timeout_cnt  output  15  current wait-counter value, for debug.

Function
REQ-014 The step table SHALL be fixed as (drive, expect):
- 0: (A0, F0)
- 1: (0B, 0F)
- 2: (AB, 00)
- 3: (01, 01)
- 4: (02, 03)
- 5: (04, none; terminal)
REQ-015 States SHALL be IDLE, DRIVE, WAIT, PASS and FAIL.
REQ-016 IDLE -> DRIVE on start; step SHALL load 0.
REQ-017 DRIVE SHALL last exactly one cycle: chk_hi_out loads drive[step], chk_hi_oeb=0, the wait counter clears, then go to WAIT.
REQ-018 chk_lo_in SHALL pass through a 2-flop synchronizer before comparison; the added latency is 2 cycles.
REQ-019 In WAIT, a match SHALL be accepted only when the synchronized input equals expect[step] for STABLE_CYCLES consecutive cycles; any mismatch restarts the stability count.
REQ-020 On acceptance, step increments and the state goes to DRIVE; if the new step is 5, DRIVE goes to PASS instead of WAIT.
REQ-021 In PASS, chk_hi_out SHALL hold 04.
REQ-022 The wait counter SHALL increment every WAIT cycle and saturate; reaching TIMEOUT_CYCLES goes to FAIL, and chk_hi_out keeps its last value.
REQ-023 Acceptance and timeout in the same cycle SHALL resolve to acceptance.
REQ-024 A start pulse in PASS or FAIL SHALL restart from step 0 and clear pass/fail.
REQ-025 A start pulse during busy SHALL be ignored.
REQ-026 Minimum step latency SHALL be 1 (DRIVE) + 2 (sync) + STABLE_CYCLES cycles.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On resetb low, asynchronously: state=IDLE, chk_hi_out=00, chk_hi_oeb=1, step=0, busy=0, pass=0, fail=0, timeout_cnt=0, and all synchronizer and stability flops cleared.
REQ-029 Reset asserted mid-sequence SHALL abort at once with no partial output; after release the block waits in IDLE for start.

Structure
REQ-030 Package gpio_hs_pkg SHALL hold the state enum, the step count, and the drive/expect table constants.
REQ-031 Sub-module gpio_hs_sync SHALL contain the 2-flop synchronizer and the STABLE_CYCLES match filter; its match output is one cycle per accepted response.
REQ-032 The top level SHALL contain the FSM, step register and timeout counter.

Verification
REQ-033 Full handshake: a bench responder answers each drive byte with its expect byte after 10 cycles -> chk_hi_out walks A0,0B,AB,01,02,04 and pass rises.
REQ-034 Glitch rejection: chk_lo_in shows F0 for 2 cycles, then 00, then F0 held (STABLE_CYCLES=4) -> step stays 0 through the glitch and advances only after the held F0.
REQ-035 Timeout: TIMEOUT_CYCLES=100 and no response at step 2 -> fail rises at WAIT cycle 100, chk_hi_out stays AB, pass stays 0.
REQ-036 Reset mid-WAIT at step 3 -> outputs return to reset values asynchronously; after release a start pulse re-drives A0.
REQ-037 Restart after PASS: a start pulse -> pass clears next cycle, step=0, chk_hi_out=A0.
REQ-038 Start while busy: a start pulse at step 1 -> no effect on step or chk_hi_out.
